mode_counter: RTL and testbench

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/mode_counter.sv | 145 ++++++++++++++
 tb/tb_mode_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// mode_counter
//   Up/down counter with a programmable upper bound (lower bound fixed at 0),
//   selectable saturate or wrap behaviour, one-cycle crossing pulses and
//   sticky crossing flags.
//
// Ports
//   i_clk         clock, all state updates on the rising edge
//   i_rst_n       asynchronous active-low reset
//   i_clr         synchronous clear of count and all flags
//   i_load        synchronous load of i_din (clamped to i_limit)
//   i_din         load value
//   i_inc/i_dec   add / subtract i_step this cycle (both or neither = hold)
//   i_step        step magnitude, zero-extended to WIDTH
//   i_wrap_mode   0 = saturate at bounds, 1 = wrap modulo limit+1
//   i_limit       programmable upper bound
//   o_count       registered counter value
//   o_at_max      count == limit (combinational)
//   o_at_zero     count == 0 (combinational)
//   o_ovf/o_unf   one-cycle pulse after an upper/lower bound crossing
//   o_ovf_sticky  set with o_ovf, cleared by clr or reset
//   o_unf_sticky  set with o_unf, cleared by clr or reset

module mode_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_din,
    input  logic              i_inc,
    input  logic              i_dec,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_wrap_mode,
    input  logic [WIDTH-1:0]  i_limit,
    output logic [WIDTH-1:0]  o_count,
    output logic              o_at_max,
    output logic              o_at_zero,
    output logic              o_ovf,
    output logic              o_unf,
    output logic              o_ovf_sticky,
    output logic              o_unf_sticky
);

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;
    logic             r_ovf_sticky;
    logic             r_unf_sticky;

    // One extra bit on every bound computation so count+step and
    // count+limit+1 never lose their carry.
    logic [WIDTH:0] w_cnt_x;
    logic [WIDTH:0] w_lim_x;
    logic [WIDTH:0] w_step_x;
    logic [WIDTH:0] w_lim_p1;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic [WIDTH:0] w_wrap_up;
    logic [WIDTH:0] w_wrap_dn;
    logic           w_step_fits;

    logic [WIDTH:0] w_next_x;
    logic           w_ovf_nxt;
    logic           w_unf_nxt;

    assign w_cnt_x     = {1'b0, r_count};
    assign w_lim_x     = {1'b0, i_limit};
    assign w_step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
    assign w_lim_p1    = w_lim_x + 1'b1;
    assign w_sum       = w_cnt_x + w_step_x;
    assign w_diff      = w_cnt_x - w_step_x;
    assign w_wrap_up   = w_sum - w_lim_p1;
    assign w_wrap_dn   = w_cnt_x + w_lim_p1 - w_step_x;
    // A step larger than the range cannot wrap meaningfully; saturate instead.
    assign w_step_fits = (w_step_x <= w_lim_x);

    always_comb begin
        w_next_x  = w_cnt_x;
        w_ovf_nxt = 1'b0;
        w_unf_nxt = 1'b0;
        if (i_clr) begin
            w_next_x = '0;
        end else if (i_load) begin
            w_next_x = (i_din > i_limit) ? w_lim_x : {1'b0, i_din};
        end else if (w_cnt_x > w_lim_x) begin
            // Limit was lowered under the count: pull back silently.
            w_next_x = w_lim_x;
        end else if (i_inc && !i_dec) begin
            if (w_sum > w_lim_x) begin
                w_ovf_nxt = 1'b1;
                w_next_x  = (i_wrap_mode && w_step_fits) ? w_wrap_up : w_lim_x;
            end else begin
                w_next_x = w_sum;
            end
        end else if (i_dec && !i_inc) begin
            if (w_step_x > w_cnt_x) begin
                w_unf_nxt = 1'b1;
                w_next_x  = (i_wrap_mode && w_step_fits) ? w_wrap_dn : '0;
            end else begin
                w_next_x = w_diff;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
        end else begin
            r_count <= w_next_x[WIDTH-1:0];
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
            if (i_clr) begin
                r_ovf_sticky <= 1'b0;
                r_unf_sticky <= 1'b0;
            end else begin
                r_ovf_sticky <= r_ovf_sticky | w_ovf_nxt;
                r_unf_sticky <= r_unf_sticky | w_unf_nxt;
            end
        end
    end

    assign o_count      = r_count;
    assign o_at_max     = (r_count == i_limit);
    assign o_at_zero    = (r_count == '0);
    assign o_ovf        = r_ovf;
    assign o_unf        = r_unf;
    assign o_ovf_sticky = r_ovf_sticky;
    assign o_unf_sticky = r_unf_sticky;

    a_din_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_load |-> !$isunknown(i_din));
    a_step_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_inc || i_dec) |-> !$isunknown(i_step));
    a_next_in_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        w_next_x[WIDTH] == 1'b0);
    a_pulse_excl : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(r_ovf && r_unf));

endmodule

// File: tb/tb_mode_counter.sv
// Directed, table-driven bench for mode_counter (WIDTH=8, STEP_W=4).

module tb_mode_counter;

    logic       clk;
    logic       rst_n;
    logic       clr, load, inc, dec, wrap_mode;
    logic [7:0] din, limit;
    logic [3:0] step;
    logic [7:0] count;
    logic       at_max, at_zero, ovf, unf, ovf_sticky, unf_sticky;

    int n_pass  = 0;
    int n_total = 0;

    mode_counter #(.WIDTH(8), .STEP_W(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clr        (clr),
        .i_load       (load),
        .i_din        (din),
        .i_inc        (inc),
        .i_dec        (dec),
        .i_step       (step),
        .i_wrap_mode  (wrap_mode),
        .i_limit      (limit),
        .o_count      (count),
        .o_at_max     (at_max),
        .o_at_zero    (at_zero),
        .o_ovf        (ovf),
        .o_unf        (unf),
        .o_ovf_sticky (ovf_sticky),
        .o_unf_sticky (unf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr, load, inc, dec, wrap;
        logic [7:0] din, limit;
        logic [3:0] step;
        logic [7:0] e_count;
        logic       e_ovf, e_unf, e_ovfs, e_unfs, e_max, e_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic l, logic i, logic d, logic w,
                                logic [7:0] dn, logic [7:0] lim, logic [3:0] st,
                                logic [7:0] ec, logic eo, logic eu, logic eos,
                                logic eus, logic emx, logic ez);
        vec_t v;
        v.clr = c; v.load = l; v.inc = i; v.dec = d; v.wrap = w;
        v.din = dn; v.limit = lim; v.step = st;
        v.e_count = ec; v.e_ovf = eo; v.e_unf = eu; v.e_ovfs = eos;
        v.e_unfs = eus; v.e_max = emx; v.e_zero = ez;
        return v;
    endfunction

    task automatic check(input string name, input logic [13:0] exp_v);
        logic [13:0] act;
        act = {count, ovf, unf, ovf_sticky, unf_sticky, at_max, at_zero};
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got cnt=%h o/u/os/us/mx/z=%b required cnt=%h o/u/os/us/mx/z=%b",
                      name, act[13:6], act[5:0], exp_v[13:6], exp_v[5:0]);
    endtask

    task automatic drive(input logic c, input logic l, input logic i, input logic d,
                         input logic w, input logic [7:0] dn, input logic [7:0] lim,
                         input logic [3:0] st);
        clr = c; load = l; inc = i; dec = d; wrap_mode = w;
        din = dn; limit = lim; step = st;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 8'h00, 8'hFF, 4'd0);
        #3;
        check("reset_state", {8'h00, 6'b000001});
        #9;
        rst_n = 1'b1;

        //            clr ld inc dec wr din    limit  st    count  o  u  os us mx z
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'hFE, 8'hFF, 4'd0, 8'hFE, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'hFF, 4'd1, 8'hFF, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'hFF, 4'd1, 8'hFF, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hFF, 4'd1, 8'hFF, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'hFF, 4'd1, 8'h00, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h01, 8'hFF, 4'd1, 8'h01, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hFF, 4'd1, 8'h00, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'hFF, 4'd1, 8'h00, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h09, 4'd0, 8'h00, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'h08, 8'h09, 4'd3, 8'h08, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h09, 4'd3, 8'h01, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 8'h00, 8'h09, 4'd3, 8'h08, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'hFF, 4'd0, 8'h00, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h0A, 8'hFF, 4'd0, 8'h0A, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'hFF, 4'd5, 8'h0A, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 8'h00, 8'hFF, 4'd5, 8'h0A, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'hFF, 4'd5, 8'h0A, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 8'h20, 8'hFF, 4'd1, 8'h20, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h40, 8'hFF, 4'd0, 8'h40, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h20, 4'd1, 8'h20, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h50, 8'h20, 4'd0, 8'h20, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'h00, 8'h05, 4'd0, 8'h00, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'h02, 8'h05, 4'd0, 8'h02, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h05, 4'd7, 8'h05, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 8'h00, 8'h05, 4'd7, 8'h00, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h05, 4'd0, 8'h00, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 8'h00, 8'h05, 4'd0, 8'h00, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h05, 4'd5, 8'h05, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'h05, 4'd1, 8'h00, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h05, 4'd2, 8'h00, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h05, 4'd2, 8'h00, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'hFF, 8'hFF, 4'd0, 8'hFF, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'h00, 8'hFF, 4'hF, 8'h0E, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 8'h00, 8'hFF, 4'hF, 8'hFF, 0, 1, 1, 1, 1, 0));

        foreach (vecs[k]) begin
            drive(vecs[k].clr, vecs[k].load, vecs[k].inc, vecs[k].dec, vecs[k].wrap,
                  vecs[k].din, vecs[k].limit, vecs[k].step);
            tick();
            check($sformatf("vec%0d", k),
                  {vecs[k].e_count, vecs[k].e_ovf, vecs[k].e_unf, vecs[k].e_ovfs,
                   vecs[k].e_unfs, vecs[k].e_max, vecs[k].e_zero});
        end

        // Async reset between edges with count=33 and ovf_sticky set.
        drive(1, 0, 0, 0, 0, 8'h00, 8'hFF, 4'd0); tick();
        drive(0, 1, 0, 0, 0, 8'hFE, 8'hFF, 4'd0); tick();
        drive(0, 0, 1, 0, 0, 8'h00, 8'hFF, 4'd5); tick();
        check("sat_ovf_pre_reset", {8'hFF, 6'b101010});
        drive(0, 1, 0, 0, 0, 8'h33, 8'hFF, 4'd0); tick();
        check("loaded_33", {8'h33, 6'b001000});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_cycle", {8'h00, 6'b000001});
        drive(0, 1, 0, 0, 0, 8'h55, 8'hFF, 4'd0);
        tick();
        check("inputs_ignored_in_reset", {8'h00, 6'b000001});
        drive(0, 0, 1, 0, 0, 8'h00, 8'hFF, 4'd3);
        #2;
        rst_n = 1'b1;
        tick();
        check("resume_after_release", {8'h03, 6'b000000});

        // Reset arriving right after a crossing edge must kill the pending pulse.
        drive(0, 0, 1, 0, 0, 8'h00, 8'h05, 4'd4); tick();
        check("sat_ovf_small_limit", {8'h05, 6'b101010});
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_discards_pulse", {8'h00, 6'b000001});
        drive(0, 0, 0, 0, 0, 8'h00, 8'hFF, 4'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("idle_after_release", {8'h00, 6'b000001});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
